// File: rtl/mips_fetch_if.sv
// Fetch-unit bus: instruction-memory req/ready and the issue valid/ack handshake.
// Decoder feedback (control_type, except, jr_target) travels with the ack.
interface mips_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_ack;
  logic [1:0]  control_type;
  logic        except;
  logic [31:0] jr_target;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata,
    output inst,
    output inst_valid,
    input  inst_ack,
    input  control_type,
    input  except,
    input  jr_target
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata,
    input  inst,
    input  inst_valid,
    output inst_ack,
    output control_type,
    output except,
    output jr_target
  );
endinterface

// File: rtl/mips_fetch_unit.sv
// MIPS fetch / next-PC unit: RST -> FETCH -> ISSUE loop, 2 cycles per inst.
// Define MIPS_FETCH_ALIGN_CHECK_EN to trap misaligned jr targets.
module mips_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter logic [31:0] EXC_PC   = 32'h8000_0180
) (
  input  logic         clock,
  input  logic         reset,
  mips_fetch_if.master bus,
  output logic [31:0]  pc,
  output logic [31:0]  epc,
  output logic         exc_pulse
);

  typedef enum logic [1:0] {
    RST,
    FETCH,
    ISSUE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] inst_q;
  logic        req;
  logic        valid;
  logic        load_inst;
  logic        adv_pc;

  logic [31:0] pc4;
  logic [31:0] br_off;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic [31:0] next_pc;
  logic        align_exc;
  logic        take_exc;
  logic        is_fall;
  logic        is_br;
  logic        is_j;
  logic        is_jr;

  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    valid     = 1'b0;
    load_inst = 1'b0;
    adv_pc    = 1'b0;
    unique case (state)
      RST: begin
        state_nxt = FETCH;
      end
      FETCH: begin
        req = 1'b1;
        if (bus.imem_ready) begin
          load_inst = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        valid = 1'b1;
        if (bus.inst_ack) begin
          adv_pc    = 1'b1;
          state_nxt = FETCH;
        end
      end
      default: begin
        state_nxt = RST;
      end
    endcase
  end

  assign bus.imem_req   = req;
  assign bus.imem_addr  = pc;
  assign bus.inst_valid = valid;
  assign bus.inst       = inst_q;

  assign pc4    = pc + 32'd4;
  assign br_off = {{14{inst_q[15]}}, inst_q[15:0], 2'b00};
  assign br_tgt = pc4 + br_off;
  assign j_tgt  = {pc4[31:28], inst_q[25:0], 2'b00};

`ifdef MIPS_FETCH_ALIGN_CHECK_EN
  assign align_exc = (bus.control_type == 2'b11) &&
                     (bus.jr_target[1:0] != 2'b00);
`else
  assign align_exc = 1'b0;
`endif

  assign take_exc = bus.except | align_exc;

  // Exception wins, so each control class is masked by it.
  assign is_fall = !take_exc && (bus.control_type == 2'b00);
  assign is_br   = !take_exc && (bus.control_type == 2'b01);
  assign is_j    = !take_exc && (bus.control_type == 2'b10);
  assign is_jr   = !take_exc && (bus.control_type == 2'b11);

  always_comb begin
    next_pc = pc4;
    unique case (1'b1)
      take_exc: next_pc = EXC_PC;
      is_fall:  next_pc = pc4;
      is_br:    next_pc = br_tgt;
      is_j:     next_pc = j_tgt;
      is_jr:    next_pc = bus.jr_target;
      default:  next_pc = pc4;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= RST;
      pc        <= RESET_PC;
      inst_q    <= 32'd0;
      epc       <= 32'd0;
      exc_pulse <= 1'b0;
    end else begin
      state     <= state_nxt;
      exc_pulse <= adv_pc & take_exc;
      if (load_inst) begin
        inst_q <= bus.imem_rdata;
      end
      if (adv_pc) begin
        pc <= next_pc;
        if (take_exc) begin
          epc <= pc;
        end
      end
    end
  end

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed bench for mips_fetch_unit: reset, streaming, a vector table of
// control transfers, then stall and mid-issue reset sequences.
module tb_mips_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc;
  logic [31:0] epc;
  logic        exc_pulse;

  int checks;
  int errors;

  mips_fetch_if bus ();

  mips_fetch_unit dut (
    .clock     (clk),
    .reset     (rst_n),
    .bus       (bus),
    .pc        (pc),
    .epc       (epc),
    .exc_pulse (exc_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  ct;
    logic        exc;
    logic [31:0] jr;
    logic [31:0] nxt;
    logic        pulse;
    logic [31:0] epc_e;
  } vec_t;

  vec_t vt [12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    logic [31:0] cur;
    logic [31:0] hold;
    checks = 0;
    errors = 0;

    // pc before each entry; nxt is the hand-computed next fetch address
    vt[0]  = '{32'h0000_0000, 2'b00, 1'b0, 32'h0, 32'h0040_000C, 1'b0, 32'h0};
    vt[1]  = '{32'h0000_0000, 2'b00, 1'b0, 32'h0, 32'h0040_0010, 1'b0, 32'h0};
    vt[2]  = '{32'h1000_0003, 2'b01, 1'b0, 32'h0, 32'h0040_0020, 1'b0, 32'h0};
    vt[3]  = '{32'h0000_0000, 2'b00, 1'b0, 32'h0, 32'h0040_0024, 1'b0, 32'h0};
    vt[4]  = '{32'h1000_FFFF, 2'b01, 1'b0, 32'h0, 32'h0040_0024, 1'b0, 32'h0};
    vt[5]  = '{32'h0800_0040, 2'b10, 1'b0, 32'h0, 32'h0000_0100, 1'b0, 32'h0};
    vt[6]  = '{32'h0000_0008, 2'b11, 1'b0, 32'h0040_0100, 32'h0040_0100,
               1'b0, 32'h0};
    vt[7]  = '{32'h0800_0040, 2'b10, 1'b1, 32'h0, 32'h8000_0180, 1'b1,
               32'h0040_0100};
`ifdef MIPS_FETCH_ALIGN_CHECK_EN
    vt[8]  = '{32'h0000_0008, 2'b11, 1'b0, 32'h0040_0102, 32'h8000_0180,
               1'b1, 32'h8000_0180};
    vt[9]  = '{32'h0000_0008, 2'b11, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC,
               1'b0, 32'h8000_0180};
    vt[10] = '{32'h0000_0000, 2'b00, 1'b0, 32'h0, 32'h0000_0000, 1'b0,
               32'h8000_0180};
    vt[11] = '{32'h0BFF_FFFF, 2'b10, 1'b0, 32'h0, 32'h0FFF_FFFC, 1'b0,
               32'h8000_0180};
`else
    vt[8]  = '{32'h0000_0008, 2'b11, 1'b0, 32'h0040_0102, 32'h0040_0102,
               1'b0, 32'h0040_0100};
    vt[9]  = '{32'h0000_0008, 2'b11, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC,
               1'b0, 32'h0040_0100};
    vt[10] = '{32'h0000_0000, 2'b00, 1'b0, 32'h0, 32'h0000_0000, 1'b0,
               32'h0040_0100};
    vt[11] = '{32'h0BFF_FFFF, 2'b10, 1'b0, 32'h0, 32'h0FFF_FFFC, 1'b0,
               32'h0040_0100};
`endif

    rst_n = 1'b0;
    bus.imem_ready   = 1'b0;
    bus.imem_rdata   = 32'h0;
    bus.inst_ack     = 1'b0;
    bus.control_type = 2'b00;
    bus.except       = 1'b0;
    bus.jr_target    = 32'h0;

    step();
    chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rst_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("rst_pulse", {31'd0, exc_pulse}, 32'd0);
    chk("rst_pc", pc, 32'h0040_0000);
    chk("rst_epc", epc, 32'h0);
    chk("rst_inst", bus.inst, 32'h0);

    // streaming: ready and ack tied high
    bus.imem_ready = 1'b1;
    bus.inst_ack   = 1'b1;
    rst_n = 1'b1;
    chk("rel_req", {31'd0, bus.imem_req}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("strm_req", {31'd0, bus.imem_req}, 32'd1);
      chk("strm_addr", bus.imem_addr, 32'h0040_0000 + 32'(i * 4));
      if (i < 2) begin
        step();
        chk("strm_valid", {31'd0, bus.inst_valid}, 32'd1);
        chk("strm_excl", {31'd0, bus.imem_req}, 32'd0);
      end
    end
    bus.inst_ack = 1'b0;

    cur = 32'h0040_0008;
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("v%0d_fetch_addr", i), bus.imem_addr, cur);
      chk($sformatf("v%0d_fetch_req", i), {31'd0, bus.imem_req}, 32'd1);
      bus.imem_ready = 1'b1;
      bus.imem_rdata = vt[i].rdata;
      step();
      bus.imem_ready = 1'b0;
      chk($sformatf("v%0d_valid", i), {31'd0, bus.inst_valid}, 32'd1);
      chk($sformatf("v%0d_req_low", i), {31'd0, bus.imem_req}, 32'd0);
      chk($sformatf("v%0d_inst", i), bus.inst, vt[i].rdata);
      chk($sformatf("v%0d_pc_hold", i), pc, cur);
      bus.inst_ack     = 1'b1;
      bus.control_type = vt[i].ct;
      bus.except       = vt[i].exc;
      bus.jr_target    = vt[i].jr;
      step();
      bus.inst_ack     = 1'b0;
      bus.control_type = 2'b00;
      bus.except       = 1'b0;
      bus.jr_target    = 32'h0;
      chk($sformatf("v%0d_next_pc", i), pc, vt[i].nxt);
      chk($sformatf("v%0d_next_addr", i), bus.imem_addr, vt[i].nxt);
      chk($sformatf("v%0d_pulse", i), {31'd0, exc_pulse},
          {31'd0, vt[i].pulse});
      chk($sformatf("v%0d_epc", i), epc, vt[i].epc_e);
      if (vt[i].pulse) begin
        step();
        chk($sformatf("v%0d_pulse_end", i), {31'd0, exc_pulse}, 32'd0);
        chk($sformatf("v%0d_pc_stall", i), pc, vt[i].nxt);
      end
      cur = vt[i].nxt;
    end

    // memory stall: 5 cycles without ready
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_req", {31'd0, bus.imem_req}, 32'd1);
      chk("stall_addr", bus.imem_addr, cur);
      chk("stall_valid", {31'd0, bus.inst_valid}, 32'd0);
    end
    bus.imem_ready = 1'b1;
    bus.imem_rdata = 32'h1234_5678;
    step();
    bus.imem_ready = 1'b0;
    bus.imem_rdata = 32'hDEAD_BEEF;
    hold = bus.inst;
    chk("iss_inst", hold, 32'h1234_5678);
    // execute stall: 3 cycles without ack
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ack_stall_valid", {31'd0, bus.inst_valid}, 32'd1);
      chk("ack_stall_inst", bus.inst, 32'h1234_5678);
      chk("ack_stall_pc", pc, cur);
      chk("ack_stall_req", {31'd0, bus.imem_req}, 32'd0);
    end

    // asynchronous reset in the middle of a cycle
    #2;
    bus.inst_ack = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("areset_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("areset_req", {31'd0, bus.imem_req}, 32'd0);
    chk("areset_pc", pc, 32'h0040_0000);
    chk("areset_epc", epc, 32'h0);
    chk("areset_inst", bus.inst, 32'h0);
    step();
    chk("areset_hold_pc", pc, 32'h0040_0000);
    bus.inst_ack = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
